ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 4: consecutive cycles a fetch request may be refused before it takes priority.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 if_req  in  1  instruction-fetch request; word read only.
REQ-005 if_addr  in  32  fetch byte address.
REQ-006 if_gnt  out  1  fetch request accepted this cycle.
REQ-007 if_rvalid  out  1  fetch response valid, one cycle after if_gnt.
REQ-008 if_rdata  out  32  fetch response word.
REQ-009 d_req  in  1  data request.
REQ-010 d_load, d_store  in  1 each  data access kind; exactly one is high when d_req is high.
REQ-011 d_funct3  in  3  RV32 load/store width encoding.
REQ-012 d_addr, d_wdata  in  32 each  data byte address and store data.
REQ-013 d_gnt  out  1  data request accepted this cycle.
REQ-014 d_rvalid  out  1  data response valid, one cycle after d_gnt.
REQ-015 d_rdata  out  32  load result; 0 for stores and faults.
REQ-016 d_fault  out  1  misaligned access, qualified by d_rvalid.
REQ-017 ram_load, ram_store  out  1 each  RAM access strobes.
REQ-018 ram_funct3  out  3; ram_addr, ram_wdata  out  32 each  RAM request fields.
REQ-019 ram_rdata  in  32  combinational RAM read data.

Function
REQ-020 Each cycle, grant at most one requester; the grant is combinational from the requests and the current state.
REQ-021 Priority state machine: D_PRI (data wins conflicts) and IF_PRI (fetch wins conflicts); reset state D_PRI.
REQ-022 wait_cnt increments when if_req is high and if_gnt is low, clears when if_gnt is high or if_req is low, and saturates at MAX_WAIT.
REQ-023 D_PRI -> IF_PRI when wait_cnt equals MAX_WAIT-1 and the fetch is refused again; IF_PRI -> D_PRI on the cycle of the next if_gnt.
REQ-024 A lone requester is always granted in the same cycle, regardless of state.
REQ-025 Fetch grant: ram_load=1, ram_funct3=LW, ram_addr={if_addr[31:2],2'b00}, ram_store=0.
REQ-026 Data grant, aligned: pass d_load, d_store, d_funct3, d_addr and d_wdata unchanged to the RAM side.
REQ-027 Misaligned: any halfword access with addr[0]=1, or any word access with addr[1:0] not 00. A misaligned data request is still granted, with ram_load=ram_store=0 (no RAM side effect).
REQ-028 Illegal funct3 on a data request is treated as misaligned.
REQ-029 No grant: ram_load=ram_store=0; ram_addr, ram_wdata and ram_funct3 are 0.
REQ-030 Response latency is exactly one cycle: ram_rdata is registered at the grant edge, and the matching *_rvalid is high for exactly the next cycle.
REQ-031 Back-to-back grants give back-to-back responses; throughput is one access per cycle.
REQ-032 d_fault=1 with d_rvalid, for one cycle, after a misaligned grant; d_rdata=0 in that case.
REQ-033 if_rdata and d_rdata hold their last values when the matching rvalid is low.
REQ-034 A requester holds req and all request fields stable until it sees its gnt.

Reset
REQ-035 While rst is high: if_gnt, d_gnt, if_rvalid, d_rvalid, d_fault, ram_load and ram_store are 0; if_rdata and d_rdata are 0; wait_cnt is 0; state is D_PRI.
REQ-036 A response whose grant edge coincides with rst high is discarded; no rvalid follows it.

Structure
REQ-037 The shared package holds the priority-state enum (D_PRI, IF_PRI) and the MAX_WAIT default, alongside the existing f3Ld/f3St encodings.
REQ-038 One combinational sub-module, misalign_check (funct3, addr[1:0] -> misaligned), computes the alignment fault.
REQ-039 The RAM stays a separate instance wired to the ram_* ports.

Verification
REQ-040 Only if_req high, if_addr=0x0000_0006, RAM word[1]=0xDEADBEEF -> if_gnt the same cycle; ram_addr=0x4; next cycle if_rvalid=1 and if_rdata=0xDEADBEEF.
REQ-041 Both requests held high for 6 cycles with MAX_WAIT=4 -> d_gnt in cycles 0-3 and if_gnt in cycle 4; in cycle 5 the state is back to D_PRI and d_gnt=1.
REQ-042 d_store SW to 0x10 with wdata=0x12345678, then d_load LB from 0x13 -> second response d_rdata=0x00000012; LH from 0x12 gives 0x00001234.
REQ-043 d_store SH to 0x11 -> d_gnt=1 and ram_store=0; next cycle d_rvalid=1, d_fault=1, d_rdata=0; RAM contents unchanged.
REQ-044 rst asserted in the cycle after a data grant -> d_rvalid stays 0 and all outputs read 0 during reset; the first post-reset conflict goes to data.
REQ-045 d_req held high continuously while if_req toggles every cycle -> no fetch waits more than MAX_WAIT cycles; wait_cnt never exceeds MAX_WAIT.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : ram_arbiter_pkg
// Brief  : Shared encodings and defaults for the fetch/data RAM arbiter.
// Rev    : 1.0
// ============================================================================
package ram_arbiter_pkg;

   typedef enum logic [2:0] {
      F3_LB  = 3'b000,
      F3_LH  = 3'b001,
      F3_LW  = 3'b010,
      F3_LBU = 3'b100,
      F3_LHU = 3'b101
   } f3Ld;

   typedef enum logic [2:0] {
      F3_SB = 3'b000,
      F3_SH = 3'b001,
      F3_SW = 3'b010
   } f3St;

   typedef enum logic [0:0] {
      D_PRI  = 1'b0,
      IF_PRI = 1'b1
   } prio_state_e;

   localparam int MAX_WAIT_DEFAULT = 4;

   // Unsigned loads have no store counterpart, so legality depends on the access kind.
   function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
      logic ok;
      ok = 1'b0;
      case (f3)
         F3_LB, F3_LH, F3_LW: ok = 1'b1;
         F3_LBU, F3_LHU:      ok = ~is_store;
         default:             ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : ram_arbiter_if
// Brief  : Fetch, data and RAM-side signal bundle for the RAM arbiter.
// Rev    : 1.0
// ============================================================================
interface ram_arbiter_if;

   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;

   logic        d_req;
   logic        d_load;
   logic        d_store;
   logic [2:0]  d_funct3;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        d_fault;

   logic        ram_load;
   logic        ram_store;
   logic [2:0]  ram_funct3;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;

   // Requesters and the RAM model together form the environment around the arbiter.
   modport master (
      output if_req, if_addr,
      output d_req, d_load, d_store, d_funct3, d_addr, d_wdata,
      output ram_rdata,
      input  if_gnt, if_rvalid, if_rdata,
      input  d_gnt, d_rvalid, d_rdata, d_fault,
      input  ram_load, ram_store, ram_funct3, ram_addr, ram_wdata
   );

   modport slave (
      input  if_req, if_addr,
      input  d_req, d_load, d_store, d_funct3, d_addr, d_wdata,
      input  ram_rdata,
      output if_gnt, if_rvalid, if_rdata,
      output d_gnt, d_rvalid, d_rdata, d_fault,
      output ram_load, ram_store, ram_funct3, ram_addr, ram_wdata
   );

endinterface
`default_nettype wire

// File: rtl/misalign_check.sv
`default_nettype none
// ============================================================================
// Module : misalign_check
// Brief  : Flags misaligned or illegal-width data accesses.
// Rev    : 1.0
// ============================================================================
module misalign_check
   import ram_arbiter_pkg::*;
(
   input  wire logic [2:0] funct3_i,
   input  wire logic [1:0] addr_lo_i,
   input  wire logic       store_i,
   output logic            misaligned_o
);

   always_comb begin
      misaligned_o = 1'b0;
      if (!f3_legal(funct3_i, store_i)) begin
         misaligned_o = 1'b1;
      end else begin
         // funct3[1:0] encodes the access size for both signed and unsigned loads.
         case (funct3_i[1:0])
            2'b01:   misaligned_o = addr_lo_i[0];
            2'b10:   misaligned_o = |addr_lo_i;
            default: misaligned_o = 1'b0;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module : ram_arbiter
// Brief  : Arbitrates fetch and data requests onto one RAM port, anti-starvation.
// Rev    : 1.0
// ============================================================================
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
   input  wire logic    clk,
   input  wire logic    rst,
   ram_arbiter_if.slave bus
);

   localparam int                 c_cnt_w    = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(MAX_WAIT);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(MAX_WAIT - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

   prio_state_e        state_q;
   logic [c_cnt_w-1:0] wait_cnt_q;

   logic               if_rvalid_q;
   logic               d_rvalid_q;
   logic               d_fault_q;
   logic [31:0]        if_rdata_q;
   logic [31:0]        d_rdata_q;

   logic               w_if_gnt;
   logic               w_d_gnt;
   logic               w_misaligned;

   misalign_check u_misalign (
      .funct3_i     (bus.d_funct3),
      .addr_lo_i    (bus.d_addr[1:0]),
      .store_i      (bus.d_store),
      .misaligned_o (w_misaligned)
   );

   always_comb begin
      w_if_gnt = 1'b0;
      w_d_gnt  = 1'b0;
      if (!rst) begin
         if (bus.if_req && (!bus.d_req || state_q == IF_PRI)) begin
            w_if_gnt = 1'b1;
         end else if (bus.d_req) begin
            w_d_gnt = 1'b1;
         end
      end
   end

   // A misaligned data grant is acknowledged but never reaches the RAM.
   always_comb begin
      bus.ram_load   = 1'b0;
      bus.ram_store  = 1'b0;
      bus.ram_funct3 = 3'b000;
      bus.ram_addr   = 32'h0;
      bus.ram_wdata  = 32'h0;
      if (w_if_gnt) begin
         bus.ram_load   = 1'b1;
         bus.ram_funct3 = F3_LW;
         bus.ram_addr   = bus.if_addr & 32'hFFFF_FFFC;
      end else if (w_d_gnt && !w_misaligned) begin
         bus.ram_load   = bus.d_load;
         bus.ram_store  = bus.d_store;
         bus.ram_funct3 = bus.d_funct3;
         bus.ram_addr   = bus.d_addr;
         bus.ram_wdata  = bus.d_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= D_PRI;
         wait_cnt_q <= '0;
      end else begin
         if (!bus.if_req || w_if_gnt) begin
            wait_cnt_q <= '0;
         end else if (wait_cnt_q != c_cnt_max) begin
            wait_cnt_q <= wait_cnt_q + c_cnt_one;
         end

         case (state_q)
            D_PRI: begin
               if (bus.if_req && !w_if_gnt && wait_cnt_q == c_cnt_last) begin
                  state_q <= IF_PRI;
               end
            end
            IF_PRI: begin
               if (w_if_gnt) begin
                  state_q <= D_PRI;
               end
            end
            default: state_q <= D_PRI;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         d_fault_q   <= 1'b0;
         if_rdata_q  <= 32'h0;
         d_rdata_q   <= 32'h0;
      end else begin
         if_rvalid_q <= w_if_gnt;
         d_rvalid_q  <= w_d_gnt;
         d_fault_q   <= w_d_gnt & w_misaligned;
         if (w_if_gnt) begin
            if_rdata_q <= bus.ram_rdata;
         end
         if (w_d_gnt) begin
            d_rdata_q <= (w_misaligned || bus.d_store) ? 32'h0 : bus.ram_rdata;
         end
      end
   end

   // Gating with rst drops a response whose grant edge precedes a reset cycle.
   assign bus.if_gnt    = w_if_gnt;
   assign bus.d_gnt     = w_d_gnt;
   assign bus.if_rvalid = if_rvalid_q & ~rst;
   assign bus.d_rvalid  = d_rvalid_q & ~rst;
   assign bus.d_fault   = d_fault_q & ~rst;
   assign bus.if_rdata  = rst ? 32'h0 : if_rdata_q;
   assign bus.d_rdata   = rst ? 32'h0 : d_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_ram_arbiter
// Brief  : Directed scoreboard bench for ram_arbiter with a behavioural RAM.
// Rev    : 1.0
// ============================================================================
module tb_ram_arbiter;

   typedef struct packed {
      logic [31:0] rdata;
      logic        fault;
   } dexp_t;

   logic        clk;
   logic        rst;
   int          total;
   int          bad;
   logic [31:0] if_q[$];
   dexp_t       d_q[$];
   logic [31:0] mem[0:63];
   logic [31:0] ram_word;
   logic [31:0] ram_sh;

   ram_arbiter_if bus ();

   ram_arbiter #(.MAX_WAIT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      ram_word = mem[bus.ram_addr[7:2]];
      ram_sh   = ram_word >> {bus.ram_addr[1:0], 3'b000};
      case (bus.ram_funct3)
         3'b000:  bus.ram_rdata = {{24{ram_sh[7]}}, ram_sh[7:0]};
         3'b001:  bus.ram_rdata = {{16{ram_sh[15]}}, ram_sh[15:0]};
         3'b100:  bus.ram_rdata = {24'h0, ram_sh[7:0]};
         3'b101:  bus.ram_rdata = {16'h0, ram_sh[15:0]};
         default: bus.ram_rdata = ram_word;
      endcase
   end

   always @(posedge clk) begin
      if (bus.ram_store) begin
         case (bus.ram_funct3)
            3'b000:  mem[bus.ram_addr[7:2]][{bus.ram_addr[1:0], 3'b000} +: 8] <= bus.ram_wdata[7:0];
            3'b001:  mem[bus.ram_addr[7:2]][{bus.ram_addr[1], 4'b0000} +: 16] <= bus.ram_wdata[15:0];
            default: mem[bus.ram_addr[7:2]] <= bus.ram_wdata;
         endcase
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard whenever a response is presented.
   always @(negedge clk) begin
      if (bus.if_rvalid) begin
         if (if_q.size() == 0) begin
            chk("if_rvalid_spurious", {31'h0, bus.if_rvalid}, 32'h0);
         end else begin
            chk("if_rdata", bus.if_rdata, if_q.pop_front());
         end
      end
      if (bus.d_rvalid) begin
         if (d_q.size() == 0) begin
            chk("d_rvalid_spurious", {31'h0, bus.d_rvalid}, 32'h0);
         end else begin
            dexp_t e;
            e = d_q.pop_front();
            chk("d_rdata", bus.d_rdata, e.rdata);
            chk("d_fault", {31'h0, bus.d_fault}, {31'h0, e.fault});
         end
      end else if (bus.d_fault) begin
         chk("d_fault_unqualified", {31'h0, bus.d_fault}, 32'h0);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.if_req   = 1'b0;
      bus.if_addr  = 32'h0;
      bus.d_req    = 1'b0;
      bus.d_load   = 1'b0;
      bus.d_store  = 1'b0;
      bus.d_funct3 = 3'b000;
      bus.d_addr   = 32'h0;
      bus.d_wdata  = 32'h0;
   endtask

   // Fetch of word 2 against an LW of word 1.
   task automatic both();
      bus.if_req   = 1'b1;
      bus.if_addr  = 32'h8;
      bus.d_req    = 1'b1;
      bus.d_load   = 1'b1;
      bus.d_store  = 1'b0;
      bus.d_funct3 = 3'b010;
      bus.d_addr   = 32'h4;
      bus.d_wdata  = 32'h0;
   endtask

   task automatic d_only(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_fault);
      cyc();
      idle();
      bus.d_req    = 1'b1;
      bus.d_load   = ld;
      bus.d_store  = st;
      bus.d_funct3 = f3;
      bus.d_addr   = a;
      bus.d_wdata  = wd;
      #1;
      chk("d_gnt", {31'h0, bus.d_gnt}, 32'h1);
      chk("ram_load", {31'h0, bus.ram_load}, {31'h0, ld & ~exp_fault});
      chk("ram_store", {31'h0, bus.ram_store}, {31'h0, st & ~exp_fault});
      if (!exp_fault) begin
         chk("ram_addr", bus.ram_addr, a);
      end
      d_q.push_back('{rdata: exp_rd, fault: exp_fault});
   endtask

   task automatic chk_reset_outputs();
      chk("rst_if_gnt", {31'h0, bus.if_gnt}, 32'h0);
      chk("rst_d_gnt", {31'h0, bus.d_gnt}, 32'h0);
      chk("rst_ram_load", {31'h0, bus.ram_load}, 32'h0);
      chk("rst_ram_store", {31'h0, bus.ram_store}, 32'h0);
      chk("rst_ram_addr", bus.ram_addr, 32'h0);
      chk("rst_if_rvalid", {31'h0, bus.if_rvalid}, 32'h0);
      chk("rst_d_rvalid", {31'h0, bus.d_rvalid}, 32'h0);
      chk("rst_d_fault", {31'h0, bus.d_fault}, 32'h0);
      chk("rst_if_rdata", bus.if_rdata, 32'h0);
      chk("rst_d_rdata", bus.d_rdata, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      total = 0;
      bad   = 0;
      for (int i = 0; i < 64; i++) begin
         mem[i] = 32'hA5A5_0000 | i;
      end
      mem[1] = 32'hDEAD_BEEF;

      // Reset with both requesters active: nothing may be granted.
      rst = 1'b1;
      both();
      repeat (2) cyc();
      #1;
      chk_reset_outputs();
      cyc();
      rst = 1'b0;
      idle();

      // Lone fetch, unaligned byte address.
      cyc();
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h6;
      #1;
      chk("f_if_gnt", {31'h0, bus.if_gnt}, 32'h1);
      chk("f_d_gnt", {31'h0, bus.d_gnt}, 32'h0);
      chk("f_ram_addr", bus.ram_addr, 32'h4);
      chk("f_ram_load", {31'h0, bus.ram_load}, 32'h1);
      chk("f_ram_funct3", {29'h0, bus.ram_funct3}, 32'h2);
      if_q.push_back(32'hDEAD_BEEF);
      cyc();
      idle();
      #1;
      chk("f_if_rvalid", {31'h0, bus.if_rvalid}, 32'h1);
      cyc();
      #1;
      chk("f_if_rvalid_drop", {31'h0, bus.if_rvalid}, 32'h0);
      chk("f_if_rdata_hold", bus.if_rdata, 32'hDEAD_BEEF);

      // Six-cycle conflict: fetch wins on cycle 4 only.
      for (int c = 0; c < 6; c++) begin
         cyc();
         both();
         #1;
         chk("conf_if_gnt", {31'h0, bus.if_gnt}, (c == 4) ? 32'h1 : 32'h0);
         chk("conf_d_gnt", {31'h0, bus.d_gnt}, (c == 4) ? 32'h0 : 32'h1);
         if (c == 4) begin
            chk("conf_ram_addr", bus.ram_addr, 32'h8);
            if_q.push_back(32'hA5A5_0002);
         end else begin
            d_q.push_back('{rdata: 32'hDEAD_BEEF, fault: 1'b0});
         end
      end
      cyc();
      idle();

      // Enter IF_PRI, then a lone data request is still served at once.
      for (int c = 0; c < 4; c++) begin
         cyc();
         both();
         #1;
         chk("pri_d_gnt", {31'h0, bus.d_gnt}, 32'h1);
         d_q.push_back('{rdata: 32'hDEAD_BEEF, fault: 1'b0});
      end
      d_only(1'b1, 1'b0, 3'b010, 32'h4, 32'h0, 32'hDEAD_BEEF, 1'b0);
      cyc();
      both();
      #1;
      chk("ifpri_if_gnt", {31'h0, bus.if_gnt}, 32'h1);
      chk("ifpri_d_gnt", {31'h0, bus.d_gnt}, 32'h0);
      if_q.push_back(32'hA5A5_0002);
      cyc();
      idle();

      // Stores, sub-word loads and misaligned/illegal accesses.
      d_only(1'b0, 1'b1, 3'b010, 32'h10, 32'h1234_5678, 32'h0, 1'b0);
      d_only(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 32'h0000_0012, 1'b0);
      d_only(1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 32'h0000_1234, 1'b0);
      d_only(1'b1, 1'b0, 3'b000, 32'h10, 32'h0, 32'h0000_0078, 1'b0);
      d_only(1'b0, 1'b1, 3'b001, 32'h11, 32'h0000_FFFF, 32'h0, 1'b1);
      d_only(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234_5678, 1'b0);
      d_only(1'b0, 1'b1, 3'b000, 32'h14, 32'h0000_0080, 32'h0, 1'b0);
      d_only(1'b1, 1'b0, 3'b000, 32'h14, 32'h0, 32'hFFFF_FF80, 1'b0);
      d_only(1'b1, 1'b0, 3'b100, 32'h14, 32'h0, 32'h0000_0080, 1'b0);
      d_only(1'b1, 1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1);
      d_only(1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
      d_only(1'b0, 1'b1, 3'b100, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b1);
      cyc();
      idle();
      #1;
      chk("mem_word4_unchanged", mem[4], 32'h1234_5678);

      // Reset right after a data grant, with state already heading to IF_PRI.
      for (int c = 0; c < 4; c++) begin
         cyc();
         both();
         #1;
         chk("pre_rst_d_gnt", {31'h0, bus.d_gnt}, 32'h1);
         if (c < 3) begin
            d_q.push_back('{rdata: 32'hDEAD_BEEF, fault: 1'b0});
         end
      end
      cyc();
      rst = 1'b1;
      #1;
      chk_reset_outputs();
      cyc();
      #1;
      chk_reset_outputs();
      cyc();
      rst = 1'b0;
      both();
      #1;
      chk("post_rst_d_gnt", {31'h0, bus.d_gnt}, 32'h1);
      chk("post_rst_if_gnt", {31'h0, bus.if_gnt}, 32'h0);
      d_q.push_back('{rdata: 32'hDEAD_BEEF, fault: 1'b0});
      cyc();
      idle();

      // Data held high while fetch toggles: the wait counter never builds up.
      for (int c = 0; c < 10; c++) begin
         cyc();
         both();
         bus.if_req = (c % 2 == 0);
         #1;
         chk("tog_d_gnt", {31'h0, bus.d_gnt}, 32'h1);
         chk("tog_if_gnt", {31'h0, bus.if_gnt}, 32'h0);
         chk("tog_wait_bound", {31'h0, (dut.wait_cnt_q <= 3'd4)}, 32'h1);
         d_q.push_back('{rdata: 32'hDEAD_BEEF, fault: 1'b0});
      end
      cyc();
      idle();

      repeat (3) cyc();
      chk("if_q_drained", if_q.size(), 32'h0);
      chk("d_q_drained", d_q.size(), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
